// File: rtl/vending_log_buffer_pkg.sv
// Shared types and helpers for the vending machine event logger.
// Operator codes, entry field layout and packing.
package vending_log_pkg;

   typedef enum logic [1:0] {
      OP_PURCHASE = 2'd0,
      OP_REFILL   = 2'd1,
      OP_FAULT    = 2'd2,
      OP_CLEAR    = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      F_P4, F_P3, F_P2, F_P1, F_OP, F_TS, F_END
   } field_e;

   localparam int ENTRY_MAX = 64;
   localparam int TS_MAX    = 32;
   localparam int PARAM_MAX = 8;

   typedef logic [ENTRY_MAX-1:0] entry_raw_t;

   // LSB offset of each field; F_END yields the full entry width
   function automatic int field_off(field_e f, int ts_w, int param_w);
      int off;
      off = 0;
      case (f)
         F_P4:    off = 0;
         F_P3:    off = param_w;
         F_P2:    off = 2 * param_w;
         F_P1:    off = 3 * param_w;
         F_OP:    off = 3 * param_w + 1;
         F_TS:    off = 3 * param_w + 3;
         default: off = 3 * param_w + 3 + ts_w;
      endcase
      return off;
   endfunction

   function automatic entry_raw_t pack_entry(
      logic [TS_MAX-1:0]    ts,
      op_e                  op,
      logic                 p1,
      logic [PARAM_MAX-1:0] p2,
      logic [PARAM_MAX-1:0] p3,
      logic [PARAM_MAX-1:0] p4,
      int                   param_w
   );
      entry_raw_t e;
      e = '0;
      e |= entry_raw_t'(p4) << field_off(F_P4, TS_MAX, param_w);
      e |= entry_raw_t'(p3) << field_off(F_P3, TS_MAX, param_w);
      e |= entry_raw_t'(p2) << field_off(F_P2, TS_MAX, param_w);
      e |= entry_raw_t'(p1) << field_off(F_P1, TS_MAX, param_w);
      e |= entry_raw_t'(op) << field_off(F_OP, TS_MAX, param_w);
      e |= entry_raw_t'(ts) << field_off(F_TS, TS_MAX, param_w);
      return e;
   endfunction

   function automatic logic [7:0] sat_inc(logic [7:0] v);
      return (v == 8'hff) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/vending_log_buffer_if.sv
// Event-in / readout handshake bundle of the event logger.
// master = controller/maintenance side, slave = logger.
interface vending_log_buffer_if
   import vending_log_pkg::*;
#(
   parameter int PARAM_W = 4,
   parameter int TS_W    = 16
);
   localparam int ENTRY_W = field_off(F_END, TS_W, PARAM_W);

   logic               op_valid;
   logic [1:0]         operator;
   logic               param1;
   logic [PARAM_W-1:0] param2;
   logic [PARAM_W-1:0] param3;
   logic [PARAM_W-1:0] param4;
   logic               rd_req;
   logic               rd_valid;
   logic [ENTRY_W-1:0] rd_entry;
   logic               rd_empty_err;

   modport master (
      output op_valid, operator, param1, param2, param3, param4, rd_req,
      input  rd_valid, rd_entry, rd_empty_err
   );

   modport slave (
      input  op_valid, operator, param1, param2, param3, param4, rd_req,
      output rd_valid, rd_entry, rd_empty_err
   );

endinterface

// File: rtl/vending_log_buffer_ring.sv
// Circular entry store: memory, read/write pointers, occupancy.
// drop advances the read pointer silently (oldest entry overwritten).
module log_ring_buffer #(
   parameter int DEPTH = 16,
   parameter int W     = 31
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     clr,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     drop,
   input  logic [W-1:0]             wdata,
   output logic [W-1:0]             rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic          adv;

   assign adv   = pop || drop;
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

   always_ff @(posedge clock) begin
      if (push) mem[wptr] <= wdata;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         rdata <= '0;
      end else if (clr) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + AW'(1);
         if (adv)  rptr <= rptr + AW'(1);
         if (pop)  rdata <= mem[rptr];
         if (push && !adv)
            count <= count + CW'(1);
         else if (!push && adv)
            count <= count - CW'(1);
      end
   end

endmodule

// File: rtl/vending_log_buffer.sv
// Timestamped event logger: op decode, full policy, event counters.
// Storage and occupancy live in log_ring_buffer.
module vending_log_buffer
   import vending_log_pkg::*;
#(
   parameter int DEPTH     = 16,
   parameter int PARAM_W   = 4,
   parameter int TS_W      = 16,
   parameter bit OVERWRITE = 1'b1
) (
   input  logic                   clock,
   input  logic                   reset,
   vending_log_buffer_if.slave    lb,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty,
   output logic [7:0]             overflow_cnt,
   output logic [7:0]             ev_cnt_purchase,
   output logic [7:0]             ev_cnt_refill,
   output logic [7:0]             ev_cnt_fault
);
   localparam int ENTRY_W = field_off(F_END, TS_W, PARAM_W);

   logic [TS_W-1:0]      ts;
   logic                 is_clr;
   logic                 is_wr;
   logic                 wipe;
   logic                 rd_ok;
   logic                 rd_err;
   logic                 lost;
   logic                 push;
   logic                 drop;
   logic [TS_MAX-1:0]    ts_x;
   logic [PARAM_MAX-1:0] p2_x;
   logic [PARAM_MAX-1:0] p3_x;
   logic [PARAM_MAX-1:0] p4_x;
   entry_raw_t           raw;
   logic [ENTRY_W-1:0]   entry;
   logic                 unused_raw;

   always_comb begin
      ts_x = '0;
      p2_x = '0;
      p3_x = '0;
      p4_x = '0;
      ts_x[TS_W-1:0]    = ts;
      p2_x[PARAM_W-1:0] = lb.param2;
      p3_x[PARAM_W-1:0] = lb.param3;
      p4_x[PARAM_W-1:0] = lb.param4;
      raw = pack_entry(ts_x, op_e'(lb.operator), lb.param1,
                       p2_x, p3_x, p4_x, PARAM_W);
      entry = raw[ENTRY_W-1:0];
   end

   assign unused_raw = ^raw[ENTRY_MAX-1:ENTRY_W];

   // CLEAR outranks both the log write and any pop in the same cycle
   always_comb begin
      is_clr = lb.op_valid && (lb.operator == OP_CLEAR);
      is_wr  = lb.op_valid && !is_clr;
      wipe   = is_clr && lb.param1;
      rd_ok  = lb.rd_req && !empty && !is_clr;
      rd_err = lb.rd_req && empty && !is_clr;
      lost   = is_wr && full && !rd_ok;
      push   = is_wr && (!lost || OVERWRITE);
      drop   = lost && OVERWRITE;
   end

   log_ring_buffer #(
      .DEPTH (DEPTH),
      .W     (ENTRY_W)
   ) u_ring (
      .clock (clock),
      .reset (reset),
      .clr   (is_clr),
      .push  (push),
      .pop   (rd_ok),
      .drop  (drop),
      .wdata (entry),
      .rdata (lb.rd_entry),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ts              <= '0;
         lb.rd_valid     <= 1'b0;
         lb.rd_empty_err <= 1'b0;
         overflow_cnt    <= '0;
         ev_cnt_purchase <= '0;
         ev_cnt_refill   <= '0;
         ev_cnt_fault    <= '0;
      end else begin
         ts              <= ts + TS_W'(1);
         lb.rd_valid     <= rd_ok;
         lb.rd_empty_err <= rd_err;
         if (wipe) begin
            overflow_cnt    <= '0;
            ev_cnt_purchase <= '0;
            ev_cnt_refill   <= '0;
            ev_cnt_fault    <= '0;
         end else begin
            if (lost) overflow_cnt <= sat_inc(overflow_cnt);
            if (is_wr) begin
               unique case (1'b1)
                  lb.operator == OP_PURCHASE:
                     ev_cnt_purchase <= sat_inc(ev_cnt_purchase);
                  lb.operator == OP_REFILL:
                     ev_cnt_refill <= sat_inc(ev_cnt_refill);
                  lb.operator == OP_FAULT:
                     ev_cnt_fault <= sat_inc(ev_cnt_fault);
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_vending_log_buffer.sv
// Directed bench: one overwrite-mode and one drop-mode logger
// driven with identical stimulus.
module tb_vending_log_buffer;

   logic clk;
   logic rst;

   logic       op_valid;
   logic [1:0] operator;
   logic       p1;
   logic [3:0] p2;
   logic [3:0] p3;
   logic [3:0] p4;
   logic       rd_req;

   logic [15:0] cyc;

   int tests;
   int fails;

   logic [4:0]  cnt   [2];
   logic        full  [2];
   logic        empty [2];
   logic [7:0]  ovf   [2];
   logic [7:0]  pur   [2];
   logic [7:0]  rfl   [2];
   logic [7:0]  flt   [2];
   logic        rv    [2];
   logic        re    [2];
   logic [30:0] ent   [2];

   vending_log_buffer_if #(.PARAM_W(4), .TS_W(16)) if0 ();
   vending_log_buffer_if #(.PARAM_W(4), .TS_W(16)) if1 ();

   assign if0.op_valid = op_valid;
   assign if0.operator = operator;
   assign if0.param1   = p1;
   assign if0.param2   = p2;
   assign if0.param3   = p3;
   assign if0.param4   = p4;
   assign if0.rd_req   = rd_req;
   assign if1.op_valid = op_valid;
   assign if1.operator = operator;
   assign if1.param1   = p1;
   assign if1.param2   = p2;
   assign if1.param3   = p3;
   assign if1.param4   = p4;
   assign if1.rd_req   = rd_req;

   assign rv[0]  = if0.rd_valid;
   assign re[0]  = if0.rd_empty_err;
   assign ent[0] = if0.rd_entry;
   assign rv[1]  = if1.rd_valid;
   assign re[1]  = if1.rd_empty_err;
   assign ent[1] = if1.rd_entry;

   vending_log_buffer #(
      .DEPTH(16), .PARAM_W(4), .TS_W(16), .OVERWRITE(1'b1)
   ) u_ovw (
      .clock           (clk),
      .reset           (rst),
      .lb              (if0.slave),
      .count           (cnt[0]),
      .full            (full[0]),
      .empty           (empty[0]),
      .overflow_cnt    (ovf[0]),
      .ev_cnt_purchase (pur[0]),
      .ev_cnt_refill   (rfl[0]),
      .ev_cnt_fault    (flt[0])
   );

   vending_log_buffer #(
      .DEPTH(16), .PARAM_W(4), .TS_W(16), .OVERWRITE(1'b0)
   ) u_drp (
      .clock           (clk),
      .reset           (rst),
      .lb              (if1.slave),
      .count           (cnt[1]),
      .full            (full[1]),
      .empty           (empty[1]),
      .overflow_cnt    (ovf[1]),
      .ev_cnt_purchase (pur[1]),
      .ev_cnt_refill   (rfl[1]),
      .ev_cnt_fault    (flt[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference cycle count: equals the logger timestamp
   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= '0;
      else     cyc <= cyc + 16'd1;
   end

   function automatic logic [30:0] mk(logic [15:0] t, logic [1:0] op,
                                      logic a, logic [3:0] b,
                                      logic [3:0] c, logic [3:0] d);
      return {t, op, a, b, c, d};
   endfunction

   task automatic idle();
      op_valid = 1'b0;
      operator = 2'd0;
      p1 = 1'b0;
      p2 = 4'd0;
      p3 = 4'd0;
      p4 = 4'd0;
      rd_req = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] op, input logic a,
                     input logic [3:0] b, input logic [3:0] c,
                     input logic [3:0] d, output logic [15:0] t);
      op_valid = 1'b1;
      operator = op;
      p1 = a;
      p2 = b;
      p3 = c;
      p4 = d;
      t = cyc;
      @(posedge clk);
      #1;
      op_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      for (int d = 0; d < 2; d++) begin
         tests++;
         if ({cnt[d], full[d], empty[d]} !== {5'd0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL reset_flags dut%0d got %h want %h", d,
                     {cnt[d], full[d], empty[d]}, {5'd0, 1'b0, 1'b1});
         end
         tests++;
         if ({ovf[d], pur[d], rfl[d], flt[d]} !== 32'd0) begin
            fails++;
            $display("FAIL reset_counters dut%0d got %h want 0", d,
                     {ovf[d], pur[d], rfl[d], flt[d]});
         end
         tests++;
         if ({rv[d], re[d], ent[d]} !== 33'd0) begin
            fails++;
            $display("FAIL reset_read dut%0d got %h want 0", d,
                     {rv[d], re[d], ent[d]});
         end
      end
   endtask

   task automatic test_basic();
      logic [15:0] t [3];
      logic [30:0] exp;
      do_reset();
      wr(2'd0, 1'b1, 4'd2, 4'd5, 4'd1, t[0]);
      tests++;
      if (cnt[0] !== 5'd1) begin
         fails++;
         $display("FAIL basic_latency got %0d want 1", cnt[0]);
      end
      wr(2'd1, 1'b1, 4'd2, 4'd5, 4'd1, t[1]);
      wr(2'd2, 1'b1, 4'd2, 4'd5, 4'd1, t[2]);
      for (int d = 0; d < 2; d++) begin
         tests++;
         if ({cnt[d], pur[d], rfl[d], flt[d]} !==
             {5'd3, 8'd1, 8'd1, 8'd1}) begin
            fails++;
            $display("FAIL basic_counts dut%0d got %h want %h", d,
                     {cnt[d], pur[d], rfl[d], flt[d]},
                     {5'd3, 8'd1, 8'd1, 8'd1});
         end
      end
      rd_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         exp = mk(t[i], 2'(i), 1'b1, 4'd2, 4'd5, 4'd1);
         for (int d = 0; d < 2; d++) begin
            tests++;
            if ({rv[d], ent[d]} !== {1'b1, exp}) begin
               fails++;
               $display("FAIL basic_pop%0d dut%0d got %h want %h", i, d,
                        {rv[d], ent[d]}, {1'b1, exp});
            end
         end
      end
      rd_req = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_overflow();
      logic [15:0] wts [20];
      logic [30:0] e0;
      logic [30:0] e1;
      do_reset();
      for (int i = 0; i < 20; i++)
         wr(2'd0, 1'b0, 4'(i), 4'd0, 4'd0, wts[i]);
      for (int d = 0; d < 2; d++) begin
         tests++;
         if ({full[d], cnt[d], ovf[d], pur[d]} !==
             {1'b1, 5'd16, 8'd4, 8'd20}) begin
            fails++;
            $display("FAIL ovf_state dut%0d got %h want %h", d,
                     {full[d], cnt[d], ovf[d], pur[d]},
                     {1'b1, 5'd16, 8'd4, 8'd20});
         end
      end
      rd_req = 1'b1;
      for (int k = 0; k < 16; k++) begin
         @(posedge clk);
         #1;
         e0 = mk(wts[k+4], 2'd0, 1'b0, 4'(k + 4), 4'd0, 4'd0);
         e1 = mk(wts[k], 2'd0, 1'b0, 4'(k), 4'd0, 4'd0);
         tests++;
         if ({rv[0], ent[0]} !== {1'b1, e0}) begin
            fails++;
            $display("FAIL ovf_pop_ovw%0d got %h want %h", k,
                     {rv[0], ent[0]}, {1'b1, e0});
         end
         tests++;
         if ({rv[1], ent[1]} !== {1'b1, e1}) begin
            fails++;
            $display("FAIL ovf_pop_drp%0d got %h want %h", k,
                     {rv[1], ent[1]}, {1'b1, e1});
         end
      end
      for (int j = 0; j < 2; j++) begin
         @(posedge clk);
         #1;
         for (int d = 0; d < 2; d++) begin
            tests++;
            if ({rv[d], re[d], empty[d]} !== 3'b011) begin
               fails++;
               $display("FAIL ovf_empty_err%0d dut%0d got %b want 011",
                        j, d, {rv[d], re[d], empty[d]});
            end
         end
      end
      rd_req = 1'b0;
      @(posedge clk);
      #1;
      tests++;
      if ({re[0], re[1]} !== 2'b00) begin
         fails++;
         $display("FAIL ovf_err_pulse got %b want 00", {re[0], re[1]});
      end
   endtask

   task automatic test_full_rw();
      logic [15:0] wts [16];
      logic [15:0] tn;
      logic [30:0] exp;
      do_reset();
      for (int i = 0; i < 16; i++)
         wr(2'd0, 1'b0, 4'(i), 4'd0, 4'd0, wts[i]);
      rd_req = 1'b1;
      wr(2'd1, 1'b1, 4'hA, 4'd3, 4'd2, tn);
      exp = mk(wts[0], 2'd0, 1'b0, 4'd0, 4'd0, 4'd0);
      for (int d = 0; d < 2; d++) begin
         tests++;
         if ({rv[d], ent[d], cnt[d], ovf[d]} !==
             {1'b1, exp, 5'd16, 8'd0}) begin
            fails++;
            $display("FAIL full_rw dut%0d got %h want %h", d,
                     {rv[d], ent[d], cnt[d], ovf[d]},
                     {1'b1, exp, 5'd16, 8'd0});
         end
      end
      for (int k = 1; k <= 16; k++) begin
         @(posedge clk);
         #1;
         if (k < 16) exp = mk(wts[k], 2'd0, 1'b0, 4'(k), 4'd0, 4'd0);
         else        exp = mk(tn, 2'd1, 1'b1, 4'hA, 4'd3, 4'd2);
         for (int d = 0; d < 2; d++) begin
            tests++;
            if ({rv[d], ent[d]} !== {1'b1, exp}) begin
               fails++;
               $display("FAIL full_rw_pop%0d dut%0d got %h want %h", k,
                        d, {rv[d], ent[d]}, {1'b1, exp});
            end
         end
      end
      rd_req = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_clear();
      logic [15:0] t;
      logic [1:0]  ops [5];
      ops = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd0};
      do_reset();
      for (int i = 0; i < 18; i++)
         wr(2'd0, 1'b0, 4'(i), 4'd0, 4'd0, t);
      rd_req = 1'b1;
      wr(2'd3, 1'b0, 4'd0, 4'd0, 4'd0, t);
      rd_req = 1'b0;
      for (int d = 0; d < 2; d++) begin
         tests++;
         if ({empty[d], cnt[d], rv[d], re[d], ovf[d], pur[d]} !==
             {1'b1, 5'd0, 1'b0, 1'b0, 8'd2, 8'd18}) begin
            fails++;
            $display("FAIL clear_keep dut%0d got %h want %h", d,
                     {empty[d], cnt[d], rv[d], re[d], ovf[d], pur[d]},
                     {1'b1, 5'd0, 1'b0, 1'b0, 8'd2, 8'd18});
         end
      end
      for (int i = 0; i < 5; i++)
         wr(ops[i], 1'b1, 4'(i), 4'd1, 4'd1, t);
      for (int d = 0; d < 2; d++) begin
         tests++;
         if ({cnt[d], pur[d], rfl[d], flt[d], ovf[d]} !==
             {5'd5, 8'd20, 8'd2, 8'd1, 8'd2}) begin
            fails++;
            $display("FAIL clear_refill dut%0d got %h want %h", d,
                     {cnt[d], pur[d], rfl[d], flt[d], ovf[d]},
                     {5'd5, 8'd20, 8'd2, 8'd1, 8'd2});
         end
      end
      rd_req = 1'b1;
      wr(2'd3, 1'b1, 4'd0, 4'd0, 4'd0, t);
      for (int d = 0; d < 2; d++) begin
         tests++;
         if ({empty[d], rv[d], re[d], ovf[d], pur[d], rfl[d], flt[d]} !==
             {1'b1, 1'b0, 1'b0, 32'd0}) begin
            fails++;
            $display("FAIL clear_wipe dut%0d got %h want %h", d,
                     {empty[d], rv[d], re[d], ovf[d], pur[d], rfl[d],
                      flt[d]}, {1'b1, 1'b0, 1'b0, 32'd0});
         end
      end
      @(posedge clk);
      #1;
      rd_req = 1'b0;
      for (int d = 0; d < 2; d++) begin
         tests++;
         if ({rv[d], re[d]} !== 2'b01) begin
            fails++;
            $display("FAIL clear_then_pop dut%0d got %b want 01", d,
                     {rv[d], re[d]});
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] t;
      logic [30:0] exp;
      do_reset();
      for (int i = 0; i < 4; i++)
         wr(2'd2, 1'b0, 4'(i), 4'd0, 4'd0, t);
      rd_req = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if ({rv[0], rv[1]} !== 2'b11) begin
         fails++;
         $display("FAIL mid_burst got %b want 11", {rv[0], rv[1]});
      end
      #3;
      rst = 1'b1;
      #1;
      for (int d = 0; d < 2; d++) begin
         tests++;
         if ({rv[d], cnt[d], empty[d], ent[d]} !==
             {1'b0, 5'd0, 1'b1, 31'd0}) begin
            fails++;
            $display("FAIL mid_reset dut%0d got %h want %h", d,
                     {rv[d], cnt[d], empty[d], ent[d]},
                     {1'b0, 5'd0, 1'b1, 31'd0});
         end
      end
      rd_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      wr(2'd2, 1'b1, 4'h7, 4'd0, 4'd0, t);
      rd_req = 1'b1;
      @(posedge clk);
      #1;
      rd_req = 1'b0;
      exp = mk(16'd1, 2'd2, 1'b1, 4'h7, 4'd0, 4'd0);
      for (int d = 0; d < 2; d++) begin
         tests++;
         if ({rv[d], ent[d]} !== {1'b1, exp}) begin
            fails++;
            $display("FAIL mid_ts_restart dut%0d got %h want %h", d,
                     {rv[d], ent[d]}, {1'b1, exp});
         end
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst = 1'b1;
      idle();
      test_reset();
      test_basic();
      test_overflow();
      test_full_rw();
      test_clear();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
